// File: rtl/int_accum_arbiter.sv
// Round-robin arbiter feeding a shared 64-bit signed accumulator with per-requester integer kinds.
// Define INT_ACCUM_SAT_EN to saturate on signed overflow instead of wrapping.
module int_accum_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ACC_W   = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ACC_W-1:0]     req_data,
  input  logic [NUM_REQ*3-1:0]         req_kind,
  input  logic                         clr,
  output logic [ACC_W-1:0]             acc,
  output logic                         acc_valid,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         ovf,
  output logic                         err
);

  localparam int unsigned ID_W   = $clog2(NUM_REQ);
  localparam int unsigned KIND_W = 3;

  localparam logic [KIND_W-1:0] K_BYTE  = 3'd0;
  localparam logic [KIND_W-1:0] K_SHORT = 3'd1;
  localparam logic [KIND_W-1:0] K_INT   = 3'd2;
  localparam logic [KIND_W-1:0] K_LONG  = 3'd3;
  localparam logic [KIND_W-1:0] K_UBYTE = 3'd4;
  localparam logic [KIND_W-1:0] K_UINT  = 3'd5;
  localparam logic [KIND_W-1:0] K_TIME  = 3'd6;
  localparam logic [KIND_W-1:0] K_RSVD  = 3'd7;

  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   sel;
  logic              found;
  logic [ACC_W-1:0]  data_sel;
  logic [KIND_W-1:0] kind_sel;
  logic [ACC_W-1:0]  operand;
  logic [ACC_W-1:0]  base;
  logic [ACC_W-1:0]  sum;
  logic [ACC_W-1:0]  acc_next;
  logic              add_ovf;

  // Search upward from ptr, wrapping, for the first valid requester; nothing is granted in reset.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!found && !rst && req_valid[j] && (((32'(ptr) + i) % NUM_REQ) == j)) begin
          found = 1'b1;
          sel   = ID_W'(j);
        end
      end
    end
  end

  // One-hot ready plus operand/kind mux of the granted requester.
  always_comb begin
    req_ready = '0;
    data_sel  = '0;
    kind_sel  = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (found && (sel == ID_W'(j))) begin
        req_ready[j] = 1'b1;
        data_sel     = req_data[j*ACC_W +: ACC_W];
        kind_sel     = req_kind[j*KIND_W +: KIND_W];
      end
    end
  end

  // Kind-dependent sign/zero extension to the accumulator width.
  always_comb begin
    operand = '0;
    case (kind_sel)
      K_BYTE:  operand = {{(ACC_W-8){data_sel[7]}}, data_sel[7:0]};
      K_SHORT: operand = {{(ACC_W-16){data_sel[15]}}, data_sel[15:0]};
      K_INT:   operand = {{(ACC_W-32){data_sel[31]}}, data_sel[31:0]};
      K_LONG:  operand = data_sel;
      K_UBYTE: operand = {{(ACC_W-8){1'b0}}, data_sel[7:0]};
      K_UINT:  operand = {{(ACC_W-32){1'b0}}, data_sel[31:0]};
      K_TIME:  operand = data_sel;
      K_RSVD:  operand = '0;
      default: operand = '0;
    endcase
  end

  // Add into the (optionally cleared) accumulator and detect signed overflow.
  always_comb begin
    base     = clr ? '0 : acc;
    sum      = base + operand;
    add_ovf  = (base[ACC_W-1] == operand[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
    acc_next = sum;
`ifdef INT_ACCUM_SAT_EN
    if (add_ovf) begin
      acc_next = base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      acc_valid <= 1'b0;
      grant_id  <= '0;
      ptr       <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      acc_valid <= found;
      if (found) begin
        acc      <= acc_next;
        grant_id <= sel;
        ptr      <= (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
        ovf      <= ovf | add_ovf;
        err      <= err | (kind_sel == K_RSVD);
      end else if (clr) begin
        acc <= '0;
      end
    end
  end

endmodule

// File: doc/int_accum_arbiter.md
INT_ACCUM_ARBITER -- requirements
Module: int_accum_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the accumulator (2..8).
REQ-002 Parameter ACC_W, default 64, accumulator width; fixed at 64 for this block.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_data  in  NUM_REQ*64  per-requester operand; only the low bits for its kind are used.
- req_kind  in  NUM_REQ*3  per-requester integer kind code, defined in REQ-006.
- clr  in  1  clear the accumulator.
- acc  out  64  accumulator value, signed two's complement.
- acc_valid  out  1  one-cycle pulse when acc was updated by an accepted operand.
- grant_id  out  clog2(NUM_REQ)  index of the last accepted requester.
- ovf  out  1  sticky signed-overflow flag.
- err  out  1  sticky reserved-kind flag.

Function
REQ-004 The block SHALL grant round-robin: it searches from pointer ptr upward, wrapping modulo NUM_REQ, and selects the first requester with valid high.
REQ-005 The block SHALL assert req_ready combinationally only for the selected requester; a transfer occurs when valid and ready are both high in the same cycle; at most one transfer occurs per cycle.
REQ-006 Kind codes SHALL map as follows:
- 0 = byte (8, signed)
- 1 = shortint (16, signed)
- 2 = int (32, signed)
- 3 = longint (64, signed)
- 4 = bit[7:0] (8, unsigned)
- 5 = int unsigned (32, unsigned)
- 6 = time (64, unsigned)
- 7 = reserved
REQ-007 The operand SHALL be the low N bits of req_data, sign-extended to 64 bits for signed kinds and zero-extended for unsigned kinds.
REQ-008 Kind 7 SHALL be accepted normally, contribute operand 0, and set err.
REQ-009 On transfer, acc SHALL become acc + operand at the next clock edge; acc_valid is high for exactly that following cycle; grant_id takes the granted index.
REQ-010 After a transfer, ptr SHALL become (granted index + 1) mod NUM_REQ; with no transfer, ptr holds.
REQ-011 clr alone SHALL set acc to 0 at the next edge, with acc_valid staying 0.
REQ-012 clr together with a transfer SHALL set acc to 0 + operand, with acc_valid set to 1.
REQ-013 Signed overflow of the 64-bit add (operands same sign, result sign differs) SHALL set ovf; ovf and err clear only on rst.
REQ-014 A requester holding valid SHALL be granted within NUM_REQ cycles; the block imposes no fairness requirement on requesters that drop valid.
REQ-015 Outputs SHALL depend only on registered state plus current req_valid (for req_ready); there is no combinational path from req_data to any output.

Reset
REQ-016 When rst is high at a clock edge, the block SHALL set acc=0, acc_valid=0, grant_id=0, ptr=0, ovf=0, err=0; req_ready is all zeros while rst is high.
REQ-017 Reset SHALL take priority over clr and over any transfer in the same cycle; an operand presented during rst is not accepted.

Configuration
REQ-018 With INT_ACCUM_SAT_EN defined, signed overflow SHALL clamp acc to 64'h7FFF_FFFF_FFFF_FFFF (positive) or 64'h8000_0000_0000_0000 (negative), and set ovf.
REQ-019 Without INT_ACCUM_SAT_EN, acc SHALL wrap modulo 2^64 and ovf is still set.

Verification
REQ-020 Scenario 1: req0 kind 0, data 8'hFF from reset -> next cycle acc=64'hFFFF_FFFF_FFFF_FFFF, acc_valid=1 for one cycle, grant_id=0.
REQ-021 Scenario 2: req1 kind 4, data 8'hFF from acc=0 -> acc=64'h0000_0000_0000_00FF; then kind 5, data 32'hFFFF_FFFF -> acc=64'h0000_0001_0000_00FE.
REQ-022 Scenario 3: all four valid continuously after reset -> grants in order 0,1,2,3,0,1, with exactly one req_ready high each cycle.
REQ-023 Scenario 4: acc=64'h7FFF_FFFF_FFFF_FFFF, req2 kind 2, data 1 -> acc=64'h8000_0000_0000_0000 and ovf=1; with INT_ACCUM_SAT_EN, acc stays 64'h7FFF_FFFF_FFFF_FFFF and ovf=1.
REQ-024 Scenario 5: acc=100, clr plus req3 kind 2, data 42 in the same cycle -> acc=42, acc_valid=1; a following cycle with clr alone -> acc=0, acc_valid=0.
REQ-025 Scenario 6: kind 7 accepted, then rst asserted mid-stream with requests pending -> err=1 before rst; after rst, acc=0, err=0, ovf=0, and the next grant goes to requester 0.
